// File: rtl/alu_pipe_unit.sv
// alu_pipe_unit: two-stage pipelined integer ALU / branch resolver feeding an in-order result FIFO.
// Optional multiplier for ops 20-23 is built only when ALU_MUL_EN is defined.
module alu_pipe_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_use_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_result,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic             out_illegal
);

  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_BEQ    = 5'd10;
  localparam logic [4:0] OP_BNE    = 5'd11;
  localparam logic [4:0] OP_BLT    = 5'd12;
  localparam logic [4:0] OP_BGE    = 5'd13;
  localparam logic [4:0] OP_BLTU   = 5'd14;
  localparam logic [4:0] OP_BGEU   = 5'd15;
  localparam logic [4:0] OP_JAL    = 5'd16;
  localparam logic [4:0] OP_JALR   = 5'd17;
  localparam logic [4:0] OP_LUI    = 5'd18;
  localparam logic [4:0] OP_AUIPC  = 5'd19;
`ifdef ALU_MUL_EN
  localparam logic [4:0] OP_MUL    = 5'd20;
  localparam logic [4:0] OP_MULH   = 5'd21;
  localparam logic [4:0] OP_MULHSU = 5'd22;
  localparam logic [4:0] OP_MULHU  = 5'd23;
`endif

  typedef struct packed {
    logic [4:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [XLEN-1:0]  imm;
    logic             use_imm;
    logic [XLEN-1:0]  pc;
    logic             c;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  result;
    logic             taken;
    logic [XLEN-1:0]  target;
    logic             illegal;
  } res_t;

  logic             alive_q, alive_d;
  logic             s1_valid_q, s1_valid_d;
  req_t             s1_q, s1_d;
  res_t             mem_q [OUT_DEPTH];
  res_t             mem_d [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  res_t             head_q, head_d;

  req_t             req_c;
  res_t             res_c;
  logic             in_ready_c;
  logic             accept_c;
  logic             push_c;
  logic             pop_c;
  logic [PTR_W-1:0] rd_nxt_c;
  logic [XLEN-1:0]  opb_c;
  logic [XLEN-1:0]  ilen_c;
  logic [XLEN-1:0]  pc_seq_c;
  logic [XLEN-1:0]  pc_imm_c;
  logic             cond_c;

  // Credit check uses only registered state, so out_ready never reaches in_ready.
  assign in_ready_c = alive_q && rdy_in && !flush_in &&
                      ((count_q + CNT_W'(s1_valid_q)) < CNT_W'(OUT_DEPTH));
  assign accept_c   = in_valid && in_ready_c;
  assign push_c     = s1_valid_q;
  assign pop_c      = out_valid_q && out_ready;
  assign rd_nxt_c   = rd_ptr_q + PTR_W'(1);

  always_comb begin
    req_c         = '0;
    req_c.op      = in_op;
    req_c.a       = in_a;
    req_c.b       = in_b;
    req_c.imm     = in_imm;
    req_c.use_imm = in_use_imm;
    req_c.pc      = in_pc;
    req_c.c       = in_c;
    req_c.tag     = in_tag;
  end

  assign opb_c    = s1_q.use_imm ? s1_q.imm : s1_q.b;
  assign ilen_c   = s1_q.c ? XLEN'(2) : XLEN'(4);
  assign pc_seq_c = s1_q.pc + ilen_c;
  assign pc_imm_c = s1_q.pc + s1_q.imm;

  // Branch condition always compares rs1 against rs2, never the immediate.
  always_comb begin
    cond_c = 1'b0;
    case (s1_q.op)
      OP_BEQ:  cond_c = (s1_q.a == s1_q.b);
      OP_BNE:  cond_c = (s1_q.a != s1_q.b);
      OP_BLT:  cond_c = ($signed(s1_q.a) <  $signed(s1_q.b));
      OP_BGE:  cond_c = ($signed(s1_q.a) >= $signed(s1_q.b));
      OP_BLTU: cond_c = (s1_q.a <  s1_q.b);
      OP_BGEU: cond_c = (s1_q.a >= s1_q.b);
      default: cond_c = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*XLEN-1:0] mul_a_c, mul_b_c, mul_p_c;

  // One shared 2*XLEN multiplier; signedness is chosen by operand extension.
  always_comb begin
    mul_a_c = {{XLEN{1'b0}}, s1_q.a};
    mul_b_c = {{XLEN{1'b0}}, s1_q.b};
    if (s1_q.op == OP_MULH || s1_q.op == OP_MULHSU) begin
      mul_a_c = {{XLEN{s1_q.a[XLEN-1]}}, s1_q.a};
    end
    if (s1_q.op == OP_MULH) begin
      mul_b_c = {{XLEN{s1_q.b[XLEN-1]}}, s1_q.b};
    end
  end

  assign mul_p_c = mul_a_c * mul_b_c;
`endif

  // S2 result computation from the S1 register.
  always_comb begin
    res_c     = '0;
    res_c.tag = s1_q.tag;
    case (s1_q.op)
      OP_ADD:  res_c.result = s1_q.a + opb_c;
      OP_SUB:  res_c.result = s1_q.a - opb_c;
      OP_AND:  res_c.result = s1_q.a & opb_c;
      OP_OR:   res_c.result = s1_q.a | opb_c;
      OP_XOR:  res_c.result = s1_q.a ^ opb_c;
      OP_SLL:  res_c.result = s1_q.a << opb_c[4:0];
      OP_SRL:  res_c.result = s1_q.a >> opb_c[4:0];
      OP_SRA:  res_c.result = XLEN'($signed(s1_q.a) >>> opb_c[4:0]);
      OP_SLT:  res_c.result = XLEN'($signed(s1_q.a) < $signed(opb_c));
      OP_SLTU: res_c.result = XLEN'(s1_q.a < opb_c);
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        res_c.taken  = cond_c;
        res_c.target = cond_c ? pc_imm_c : pc_seq_c;
      end
      OP_JAL: begin
        res_c.result = pc_seq_c;
        res_c.taken  = 1'b1;
        res_c.target = pc_imm_c;
      end
      OP_JALR: begin
        res_c.result = pc_seq_c;
        res_c.taken  = 1'b1;
        res_c.target = (s1_q.a + s1_q.imm) & ~XLEN'(1);
      end
      OP_LUI:   res_c.result = s1_q.imm;
      OP_AUIPC: res_c.result = pc_imm_c;
`ifdef ALU_MUL_EN
      OP_MUL:   res_c.result = mul_p_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_c.result = mul_p_c[2*XLEN-1:XLEN];
`endif
      default:  res_c.illegal = 1'b1;
    endcase
  end

  // Next-state: S1 advance, FIFO push/pop, and registered head tracking.
  always_comb begin
    alive_d     = 1'b1;
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    head_d      = head_q;
    mem_d       = mem_q;
    if (rdy_in) begin
      if (flush_in) begin
        s1_valid_d  = 1'b0;
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        count_d     = '0;
        out_valid_d = 1'b0;
      end else begin
        s1_valid_d = accept_c;
        if (accept_c) begin
          s1_d = req_c;
        end
        if (push_c) begin
          mem_d[wr_ptr_q] = res_c;
          wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
          rd_ptr_d = rd_nxt_c;
        end
        count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        out_valid_d = (count_d != '0);
        // Head holds its last contents whenever the FIFO drains empty.
        if (count_q == '0 && push_c) begin
          head_d = res_c;
        end else if (pop_c && count_q == CNT_W'(1) && push_c) begin
          head_d = res_c;
        end else if (pop_c && count_q > CNT_W'(1)) begin
          head_d = mem_q[rd_nxt_c];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      alive_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      alive_q     <= alive_d;
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
      mem_q       <= mem_d;
    end
  end

  assign in_ready    = in_ready_c;
  assign out_valid   = out_valid_q;
  assign out_tag     = head_q.tag;
  assign out_result  = head_q.result;
  assign out_taken   = head_q.taken;
  assign out_target  = head_q.target;
  assign out_illegal = head_q.illegal;

endmodule

// File: doc/alu_pipe_unit.md
Name: alu_pipe_unit

Overview:
- Parametrised, pipelined successor to the single-cycle integer ALU in the execute stage.
- Accepts issued ops from the reservation station over a valid/ready handshake, computes over a two-stage pipeline, and buffers results in an OUT_DEPTH-entry FIFO toward the CDB arbiter.
- Adds backpressure, mispredict flush, ROB tagging, correct signed/arithmetic semantics, and branch/jump resolution with separate taken/target outputs.

Parameters:
- XLEN, 32, datapath width in bits.
- TAG_W, 4, ROB tag width.
- OUT_DEPTH, 4, result FIFO entries; power of two, at least 2.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, asynchronous active-low reset.
- rdy_in, input, 1, global ready; low freezes the whole unit.
- flush_in, input, 1, mispredict flush; synchronous, active-high.
- in_valid, input, 1, issue request.
- in_ready, output, 1, unit can accept this cycle.
- in_op, input, 5, operation code (encoding below).
- in_a, input, XLEN, operand rs1.
- in_b, input, XLEN, operand rs2.
- in_imm, input, XLEN, immediate, already sign-extended by the decoder.
- in_use_imm, input, 1, operand B = in_imm instead of in_b (ALU ops only).
- in_pc, input, XLEN, instruction PC.
- in_c, input, 1, compressed instruction (instruction length 2, else 4).
- in_tag, input, TAG_W, ROB tag.
- out_valid, output, 1, FIFO head valid.
- out_ready, input, 1, consumer pops the head.
- out_tag, output, TAG_W, head tag.
- out_result, output, XLEN, head result.
- out_taken, output, 1, head branch/jump taken.
- out_target, output, XLEN, head redirect target.
- out_illegal, output, 1, head op was unsupported.

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
  - 16 JAL, 17 JALR, 18 LUI, 19 AUIPC.
  - 20 MUL, 21 MULH, 22 MULHSU, 23 MULHU.
  - 24-31 illegal.
- ALU ops (0-9):
  - B = in_use_imm ? in_imm : in_b.
  - Shifts use B[4:0]; SRA is arithmetic.
  - SLT compares signed; SLTU compares unsigned; result is 0 or 1.
  - out_taken=0, out_target=0.
- Branches (10-15):
  - Compare in_a with in_b; in_use_imm is ignored.
  - out_result=0.
  - out_taken = condition met.
  - out_target = taken ? pc+imm : pc+ilen, where ilen = in_c ? 2 : 4.
- Jumps and upper-immediate ops:
  - JAL: result = pc+ilen, taken=1, target = pc+imm.
  - JALR: result = pc+ilen, taken=1, target = (a+imm) & ~1.
  - LUI: result = imm.
  - AUIPC: result = pc+imm.
- All arithmetic wraps modulo 2^XLEN.
- Illegal ops: result=0, taken=0, target=0, out_illegal=1. The op still flows through and is never dropped.
- Pipeline:
  - S1 registers the accepted request.
  - S2 computes and pushes into the FIFO on the next edge.
  - Request accepted at edge N appears at the FIFO head (out_valid=1) after edge N+1 when the FIFO was empty. Latency is 2.
  - Order is strictly in-order.
- Handshake:
  - Accept when in_valid && in_ready && rdy_in.
  - Pop when out_valid && out_ready && rdy_in.
  - in_ready = rdy_in && !flush_in && (fifo_count + s1_valid < OUT_DEPTH); uses registered count, so no combinational path from out_ready.
  - S1 never stalls: a credit is reserved at acceptance.
- Boundaries:
  - Full FIFO: in_ready=0. A same-cycle pop frees a credit only from the next cycle.
  - Empty FIFO: out_valid=0, and out_* hold the last-written head contents.
  - Push and pop in the same cycle: both happen, count unchanged.
  - Read and write pointers wrap modulo OUT_DEPTH.
- rdy_in low: no accept, no pop, no S1 advance. All state and outputs hold. flush_in is also ignored.
- flush_in high (with rdy_in high):
  - Clears s1_valid, FIFO pointers and count on that edge.
  - A same-cycle in_valid is not accepted.
  - out_valid=0 from the next cycle.
- Reset (rst_in low, asynchronous): s1_valid=0, pointers=0, count=0, out_valid=0, in_ready=0, out_tag=0, out_result=0, out_taken=0, out_target=0, out_illegal=0. Reset mid-operation discards all in-flight ops.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: ops 20-23 return the low XLEN bits (MUL) or high XLEN bits of the 2*XLEN product with signed×signed (MULH), signed×unsigned (MULHSU) or unsigned×unsigned (MULHU) operands. Computed in S2 with the same latency; out_illegal=0.
- Undefined: no multiplier is synthesised; ops 20-23 are treated as illegal (result=0, out_illegal=1).

Test Plan:
- Reset, then SUB a=5 b=7 tag=3, out_ready=1 -> 2 cycles later out_valid=1, tag=3, result=0xFFFFFFFE; next cycle out_valid=0.
- SLT a=0xFFFFFFFF b=1 -> result 1; SLTU same operands -> result 0; SRA a=0x80000000 imm=4 use_imm -> result 0xF8000000.
- BEQ pc=0x100 a=b=9 imm=0x20 in_c=0 -> taken=1, target 0x120; BNE with the same operands -> taken=0, target 0x104; with in_c=1 -> target 0x102. JALR a=0x203 imm=4 pc=0x40 -> result 0x44, target 0x206.
- out_ready=0, issue 6 back-to-back ops at OUT_DEPTH=4 -> exactly 4 accepted, in_ready=0; raise out_ready -> results pop in issue order, then the remaining 2 are accepted.
- Fill FIFO with 3 ops, assert flush_in together with in_valid -> that op is not accepted; out_valid=0 next cycle; a new op issued afterwards appears alone.
- Hold rdy_in=0 for 3 cycles mid-stream -> no outputs change, no accept or pop; resume -> no loss or duplication. MULHU 0xFFFFFFFF×2 -> result 1 with ALU_MUL_EN defined, out_illegal=1 without it.
